multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the 16-bit CPU.
- Sequences fetch/decode/execute/memory/writeback.
- Drives the immediate-extender select code (imm_load), instruction-register load, PC write, register-file write and the shared memory port.
- Sits between instruction memory/data memory arbitration and the datapath.
- One instruction in flight; memory accesses use a req/ready handshake.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/multicycle_ctrl_opcode_decoder.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: FSM state
// encodings, 5-bit opcode constants and immediate-extender select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW     = 5'b11011;

    // Extender select meanings (codes 3 and 7 are not produced).
    localparam logic [2:0] IMM_SE8  = 3'd0;
    localparam logic [2:0] IMM_SE4  = 3'd1;
    localparam logic [2:0] IMM_SE11 = 3'd2;
    localparam logic [2:0] IMM_ZE8  = 3'd4;
    localparam logic [2:0] IMM_SE5  = 3'd5;
    localparam logic [2:0] IMM_SH3  = 3'd6;

endpackage

// File: rtl/multicycle_ctrl_opcode_decoder.sv
// Combinational opcode classifier for the multi-cycle controller.
// Ports: opc in; imm_sel, is_branch, is_cond, is_load, is_store, legal out.
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [4:0] opc,
    output logic [2:0] imm_sel,
    output logic       is_branch,
    output logic       is_cond,
    output logic       is_load,
    output logic       is_store,
    output logic       legal
);

    always_comb begin
        imm_sel   = IMM_SE8;
        is_branch = 1'b0;
        is_cond   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        legal     = 1'b1;
        unique case (opc)
            OP_ADDIU:  imm_sel = IMM_SE8;
            OP_ADDIU3: imm_sel = IMM_SE4;
            OP_LI:     imm_sel = IMM_ZE8;
            OP_SHIFT:  imm_sel = IMM_SH3;
            OP_B: begin
                imm_sel   = IMM_SE11;
                is_branch = 1'b1;
            end
            OP_BEQZ: begin
                imm_sel   = IMM_SE8;
                is_branch = 1'b1;
                is_cond   = 1'b1;
            end
            OP_LW: begin
                imm_sel = IMM_SE5;
                is_load = 1'b1;
            end
            OP_SW: begin
                imm_sel  = IMM_SE5;
                is_store = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the 16-bit CPU.
// Ports: clk, rst (async, active-high), instr_in, zero_flag, mem_ready in;
//   mem_req/we/sel, ir_load, pc_write, pc_src, imm_load, reg_write,
//   wb_sel, illegal, state_o out. Define MEM_TIMEOUT_EN to add a memory
//   wait watchdog (TIMEOUT_CYCLES) and the sticky bus_err output.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 5
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_src,
    output logic [2:0]  imm_load,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        illegal,
    output logic [2:0]  state_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_sel_q, mem_sel_d;
    logic             mem_we_q, mem_we_d;
    logic             reg_write_q, reg_write_d;
    logic             wb_sel_q, wb_sel_d;
    logic             illegal_q, illegal_d;
    logic [2:0]       imm_q, imm_d;

    logic [2:0] dec_imm;
    logic       dec_br, dec_cond, dec_ld, dec_st, dec_legal;
    logic       accept;
    logic       timeout;
    logic       unused_bits;

    assign unused_bits = ^instr_in[15-OPC_W:0];

    // mem_req_q is only ever high in FETCH/MEM, so this alone qualifies
    // mem_ready; stray ready pulses elsewhere are ignored.
    assign accept = mem_req_q & mem_ready;

    opcode_decoder u_dec (
        .opc       (opc_q),
        .imm_sel   (dec_imm),
        .is_branch (dec_br),
        .is_cond   (dec_cond),
        .is_load   (dec_ld),
        .is_store  (dec_st),
        .legal     (dec_legal)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    assign timeout = mem_req_q & ~mem_ready &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | timeout;
        if (accept || timeout) begin
            cnt_d = '0;
        end else if (mem_req_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            opc_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= 1'b0;
            illegal_q   <= 1'b0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            mem_req_q   <= mem_req_d;
            mem_sel_q   <= mem_sel_d;
            mem_we_q    <= mem_we_d;
            reg_write_q <= reg_write_d;
            wb_sel_q    <= wb_sel_d;
            illegal_q   <= illegal_d;
            imm_q       <= imm_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (accept) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = dec_legal ? ST_EXEC : ST_FETCH;
            end
            ST_EXEC: begin
                if (dec_br) begin
                    state_d = ST_FETCH;
                end else if (dec_ld || dec_st) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (accept) begin
                    state_d = dec_ld ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Output logic. Strobes are registered from the next state so they
    // line up with the state they belong to; ir_load/pc_write/pc_src
    // stay combinational because the datapath must capture in the same
    // cycle as mem_ready / zero_flag.
    always_comb begin
        opc_d       = opc_q;
        imm_d       = imm_q;
        wb_sel_d    = wb_sel_q;
        illegal_d   = illegal_q;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        mem_req_d   = ((state_d == ST_FETCH) || (state_d == ST_MEM)) &
                      ~timeout;
        mem_sel_d   = (state_d == ST_MEM);
        mem_we_d    = (state_d == ST_MEM) & dec_st;
        reg_write_d = (state_d == ST_WB);

        if (state_d == ST_WB) begin
            wb_sel_d = (state_q == ST_MEM);
        end

        unique case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    opc_d    = instr_in[15 -: OPC_W];
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    imm_d = dec_imm;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (dec_br && (!dec_cond || zero_flag)) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_sel   = mem_sel_q;
    assign mem_we    = mem_we_q;
    assign reg_write = reg_write_q;
    assign wb_sel    = wb_sel_q;
    assign illegal   = illegal_q;
    assign imm_load  = imm_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push the
// expected output events; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr_in = '0;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_sel, ir_load, pc_write, pc_src;
    logic [2:0]  imm_load;
    logic        reg_write, wb_sel, illegal;
    logic [2:0]  state_o;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .instr_in  (instr_in),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .ir_load   (ir_load),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .imm_load  (imm_load),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .state_o   (state_o)
`ifdef MEM_TIMEOUT_EN
        ,
        .bus_err   (bus_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       wb_sel;
        logic       illegal;
        logic [2:0] imm;
        logic [2:0] st;
        logic       mem_acc;
        logic       mem_sel;
        logic       mem_we;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    logic [2:0] cur_imm = 3'd0;
    logic       cur_wb  = 1'b0;
    logic       cur_ill = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any strobe or memory acceptance is an output event.
    always @(negedge clk) begin
        ev_t got;
        ev_t e;
        if (!rst && (ir_load || pc_write || reg_write ||
                     (mem_req && mem_ready))) begin
            got = {ir_load, pc_write, pc_src, reg_write, wb_sel, illegal,
                   imm_load, state_o, mem_req & mem_ready, mem_sel, mem_we};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got %h expected none",
                         got);
            end else begin
                e = exp_q.pop_front();
                check("event", 32'(got), 32'(e));
            end
        end
    end

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!mem_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = mem_req;
        if (!ok) check("mem_req_wait", 32'(mem_req), 32'd1);
    endtask

    // Memory responder: ready after dly wait cycles, returns the cycle of
    // acceptance.
    task automatic handshake(input int dly, input logic [15:0] data,
                             output int t);
        bit ok;
        wait_req(ok);
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        t = cyc;
        mem_ready = 1'b1;
        instr_in  = data;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        instr_in  = 16'h0000;
    endtask

    task automatic run(input logic [15:0] instr, input logic zf,
                       input int dly, input logic [2:0] imm,
                       input logic legal, input logic taken,
                       input logic regw, input logic wbs,
                       input logic mem, input logic we, input int cpi);
        ev_t        e;
        logic [2:0] nimm;
        int         t0, t1;
        bit         ok;
        nimm = legal ? imm : cur_imm;
        zero_flag = zf;
        e = '{ir_load: 1'b1, pc_write: 1'b1, pc_src: 1'b0,
              reg_write: 1'b0, wb_sel: cur_wb, illegal: cur_ill,
              imm: cur_imm, st: 3'd0, mem_acc: 1'b1, mem_sel: 1'b0,
              mem_we: 1'b0};
        exp_q.push_back(e);
        if (mem) begin
            e = '{ir_load: 1'b0, pc_write: 1'b0, pc_src: 1'b0,
                  reg_write: 1'b0, wb_sel: cur_wb, illegal: cur_ill,
                  imm: nimm, st: 3'd3, mem_acc: 1'b1, mem_sel: 1'b1,
                  mem_we: we};
            exp_q.push_back(e);
        end
        if (taken) begin
            e = '{ir_load: 1'b0, pc_write: 1'b1, pc_src: 1'b1,
                  reg_write: 1'b0, wb_sel: cur_wb, illegal: cur_ill,
                  imm: nimm, st: 3'd2, mem_acc: 1'b0, mem_sel: 1'b0,
                  mem_we: 1'b0};
            exp_q.push_back(e);
        end
        if (regw) begin
            e = '{ir_load: 1'b0, pc_write: 1'b0, pc_src: 1'b0,
                  reg_write: 1'b1, wb_sel: wbs, illegal: cur_ill,
                  imm: nimm, st: 3'd4, mem_acc: 1'b0, mem_sel: 1'b0,
                  mem_we: 1'b0};
            exp_q.push_back(e);
        end
        handshake(0, instr, t0);
        // Data phase returns an illegal-looking word; it must not be
        // taken as an opcode.
        if (mem) handshake(dly, 16'hF800, t1);
        wait_req(ok);
        check($sformatf("cpi_%h", instr), 32'(cyc - t0), 32'(cpi));
        cur_imm = nimm;
        if (regw) cur_wb = wbs;
        if (!legal) cur_ill = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_strobes",
              32'({mem_req, mem_we, mem_sel, ir_load, pc_write, pc_src,
                   reg_write}), 32'd0);
        check("rst_regs", 32'({imm_load, wb_sel, illegal}), 32'd0);
`ifdef MEM_TIMEOUT_EN
        check("rst_bus_err", 32'(bus_err), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        //   instr     zf  dly imm   lg   tk   rw   wbs  mem  we   cpi
        run(16'h4905, 1'b1, 0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        run(16'h4123, 1'b0, 0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        run(16'h6812, 1'b1, 0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        run(16'h3045, 1'b0, 0, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        run(16'h9821, 1'b0, 3, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8);
        run(16'h9821, 1'b1, 0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        run(16'hD821, 1'b0, 0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        run(16'hD821, 1'b0, 2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6);
        run(16'h1007, 1'b0, 0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run(16'h2003, 1'b1, 0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run(16'h2003, 1'b0, 0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run(16'hF800, 1'b0, 0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        run(16'h6812, 1'b0, 0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);

        // Asynchronous reset while a fetch request is pending.
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", 32'({mem_req, mem_sel, mem_we}), 32'd0);
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_illegal", 32'(illegal), 32'd0);
        check("arst_imm", 32'(imm_load), 32'd0);
        cur_imm = 3'd0;
        cur_wb  = 1'b0;
        cur_ill = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(16'h4123, 1'b0, 0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);

`ifdef MEM_TIMEOUT_EN
        begin
            ev_t e;
            int  t0, ts, n;
            bit  ok;
            e = '{ir_load: 1'b1, pc_write: 1'b1, pc_src: 1'b0,
                  reg_write: 1'b0, wb_sel: cur_wb, illegal: cur_ill,
                  imm: cur_imm, st: 3'd0, mem_acc: 1'b1, mem_sel: 1'b0,
                  mem_we: 1'b0};
            exp_q.push_back(e);
            handshake(0, 16'h9821, t0);
            wait_req(ok);
            ts = cyc;
            n = 0;
            while (!bus_err && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("to_cycles", 32'(cyc - ts), 32'd16);
            check("to_bus_err", 32'(bus_err), 32'd1);
            check("to_state", 32'(state_o), 32'd0);
            check("to_req_drop", 32'(mem_req), 32'd0);
            cur_imm = 3'd5;
            run(16'h4905, 1'b0, 0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b0, 4);
            check("to_bus_err_sticky", 32'(bus_err), 32'd1);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
